// File: rtl/rpn_pkg.sv
// rpn_pkg: constants shared by the RPN calculator blocks (stack-pointer FSM,
// operand stack, ALU).
//   CMD_*       2-bit command encoding issued to the operand stack
//   RPN_WIDTH   default operand width
//   RPN_DEPTH   default operand stack depth
package rpn_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_PUSH  = 2'b01;
  localparam logic [1:0] CMD_POP   = 2'b10;
  localparam logic [1:0] CMD_BINOP = 2'b11;

  localparam int RPN_WIDTH = 8;
  localparam int RPN_DEPTH = 16;

endpackage

// File: rtl/rpn_stack_ram.sv
// rpn_stack_ram: DEPTH x WIDTH register file backing the operand stack.
//   CLOCK_50  in   write clock, rising edge
//   wr_en     in   write enable
//   wr_addr   in   write address
//   wr_data   in   write data
//   rd_addr   in   asynchronous read address
//   rd_data   out  read data; 0 for an address beyond DEPTH-1
// Contents are not reset.
module rpn_stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLOCK_50,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLOCK_50) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-power-of-two depths leave address codes with no backing entry.
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < DEPTH) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/rpn_stack.sv
// rpn_stack: LIFO operand stack for the RPN calculator with the top two
// entries cached in registers so the ALU sees both operands immediately.
//   CLOCK_50     in   system clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   clear        in   synchronous clear of stack and flags, overrides cmd
//   cmd          in   00 NOP, 01 PUSH, 10 POP, 11 BINOP
//   push_data    in   operand for PUSH
//   result_data  in   ALU result for BINOP (from tos/nos this cycle)
//   tos, nos     out  cached top / next-on-stack, 0 when not present
//   depth        out  number of valid entries
//   full, empty  out  decoded from depth
//   overflow     out  sticky, PUSH while full
//   underflow    out  sticky, POP while empty or BINOP with depth < 2
//   cmd_ok       out  registered acceptance of the previous command
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int WIDTH = RPN_WIDTH,
  parameter int DEPTH = RPN_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             clear,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] result_data,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CNT_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  output logic             cmd_ok
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] THREE   = CNT_W'(3);

  logic [CNT_W-1:0] depth_q;
  logic [WIDTH-1:0] tos_q;
  logic [WIDTH-1:0] nos_q;
  logic             ovf_q;
  logic             unf_q;
  logic             ok_q;

  logic             push_ok;
  logic             pop_ok;
  logic             bin_ok;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] refill;

  assign full  = (depth_q == DEPTH_C);
  assign empty = (depth_q == '0);

  always_comb begin
    push_ok = (cmd == CMD_PUSH)  && !full;
    pop_ok  = (cmd == CMD_POP)   && !empty;
    bin_ok  = (cmd == CMD_BINOP) && (depth_q >= TWO);
    wr_en   = !clear && (push_ok || bin_ok);
    // PUSH appends at depth; BINOP overwrites the entry that held nos.
    wr_addr = push_ok ? AW'(depth_q) : AW'(depth_q - TWO);
    wr_data = push_ok ? push_data : result_data;
    // Entry below nos becomes the new nos after POP/BINOP. The subtraction
    // wraps when depth < 3, so the data is discarded in that case.
    rd_addr = AW'(depth_q - THREE);
    refill  = (depth_q >= THREE) ? rd_data : '0;
  end

  rpn_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLOCK_50 (CLOCK_50),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      depth_q <= '0;
      tos_q   <= '0;
      nos_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else if (clear) begin
      depth_q <= '0;
      tos_q   <= '0;
      nos_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      ok_q <= push_ok || pop_ok || bin_ok;
      unique case (cmd)
        CMD_PUSH: begin
          if (push_ok) begin
            nos_q   <= tos_q;
            tos_q   <= push_data;
            depth_q <= depth_q + 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        CMD_POP: begin
          if (pop_ok) begin
            tos_q   <= nos_q;
            nos_q   <= refill;
            depth_q <= depth_q - 1'b1;
          end else begin
            unf_q <= 1'b1;
          end
        end
        CMD_BINOP: begin
          if (bin_ok) begin
            tos_q   <= result_data;
            nos_q   <= refill;
            depth_q <= depth_q - 1'b1;
          end else begin
            unf_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tos       = tos_q;
  assign nos       = nos_q;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign cmd_ok    = ok_q;

endmodule
